// File: rtl/display_mode_sequencer.sv
// Display-path mode sequencer: debounces and validates the mode switches, then commits a new
// one-hot select only at a fixed point inside vertical blank. Optional feature macro: DISPLAY_AUTO_CYCLE_EN.
module display_mode_sequencer #(
    parameter int                SEL_W         = 18,
    parameter int                STABLE_CYCLES = 1024,
    parameter int                VBLANK_CYCLES = 50,
    parameter int                BLANK_FRAMES  = 1,
    parameter logic [SEL_W-1:0]  DEFAULT_MODE  = SEL_W'(2)
`ifdef DISPLAY_AUTO_CYCLE_EN
    ,
    parameter int                AUTO_FRAMES   = 60
`endif
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iFval,
`ifdef DISPLAY_AUTO_CYCLE_EN
    input  logic             iAuto,
`endif
    input  logic [SEL_W-1:0] iSwitch,
    output logic [SEL_W-1:0] oSelect,
    output logic             oBlank,
    output logic             oSwitching,
    output logic             oErr,
    output logic [15:0]      oFrameCount
);

    localparam int               DCNT_W     = $clog2(STABLE_CYCLES + 1);
    localparam logic [DCNT_W-1:0] STABLE_MAX = DCNT_W'(STABLE_CYCLES);
    localparam logic [7:0]        VB_LAST    = 8'(VBLANK_CYCLES - 1);
    localparam logic [3:0]        BLANK_INIT = 4'(BLANK_FRAMES);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        BLANK
    } state_t;

    logic [SEL_W-1:0]  syncMeta_q;
    logic [SEL_W-1:0]  syncOut_q;
    logic [SEL_W-1:0]  cand_q;
    logic [DCNT_W-1:0] dcnt_q;
    logic [DCNT_W-1:0] dcnt_d;
    logic [7:0]        vcnt_q;
    logic [7:0]        vcnt_d;
    logic              fval_q;
    logic [15:0]       frameCnt_q;
    logic [SEL_W-1:0]  pend_q;
    logic [3:0]        bcnt_q;
    state_t            state_q;
    logic [SEL_W-1:0]  select_q;
    logic              blank_q;
    logic              switching_q;
    logic              err_q;

    logic reqStable;
    logic reqOk;
    logic swReq;
    logic commit;

    // Two-flop synchroniser followed by a candidate/run-length debouncer.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            syncMeta_q <= '0;
            syncOut_q  <= '0;
            cand_q     <= '0;
            dcnt_q     <= '0;
        end else begin
            syncMeta_q <= iSwitch;
            syncOut_q  <= syncMeta_q;
            if (syncOut_q != cand_q) begin
                cand_q <= syncOut_q;
                dcnt_q <= '0;
            end else begin
                dcnt_q <= dcnt_d;
            end
        end
    end

    assign dcnt_d    = (dcnt_q == STABLE_MAX) ? dcnt_q : dcnt_q + 1'b1;
    assign reqStable = (dcnt_q == STABLE_MAX);
    assign reqOk     = reqStable && $onehot(cand_q);

    // The commit point is the VBLANK_CYCLES-th consecutive low sample, so it fires once per blank.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            vcnt_q     <= '0;
            fval_q     <= 1'b0;
            frameCnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            vcnt_q <= vcnt_d;
            fval_q <= iFval;
            if (iFval && !fval_q) begin
                frameCnt_q <= frameCnt_q + 16'd1;
            end
            err_q <= reqStable && !reqOk;
        end
    end

    assign vcnt_d = iFval ? 8'd0 : ((vcnt_q == 8'hFF) ? vcnt_q : vcnt_q + 8'd1);
    assign commit = !iFval && (vcnt_q == VB_LAST);

`ifdef DISPLAY_AUTO_CYCLE_EN
    localparam int              AUTO_W    = $clog2(AUTO_FRAMES + 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_FRAMES - 1);

    logic [AUTO_W-1:0] autoCnt_q;
    logic [SEL_W-1:0]  autoNext;
    logic              autoFire;

    // Rotation stays inside the bits [8:1] window; a select outside it restarts at the default.
    always_comb begin
        autoNext      = '0;
        autoNext[8:1] = {select_q[7:1], select_q[8]};
        if (autoNext == '0) begin
            autoNext = DEFAULT_MODE;
        end
    end

    assign autoFire = iAuto && (state_q == IDLE) && commit && (autoCnt_q == AUTO_LAST);
    assign swReq    = reqOk && !iAuto;

    always_ff @(posedge iClk) begin
        if (!iRst_n || !iAuto) begin
            autoCnt_q <= '0;
        end else if ((state_q == IDLE) && commit) begin
            autoCnt_q <= autoFire ? '0 : autoCnt_q + 1'b1;
        end
    end
`else
    assign swReq = reqOk;
`endif

    // Request/commit FSM; oSwitching tracks the state being entered so it is registered with it.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            bcnt_q      <= '0;
            select_q    <= DEFAULT_MODE;
            blank_q     <= 1'b0;
            switching_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
`ifdef DISPLAY_AUTO_CYCLE_EN
                    if (autoFire) begin
                        pend_q      <= autoNext;
                        state_q     <= PENDING;
                        switching_q <= 1'b1;
                    end else
`endif
                    if (swReq && (cand_q != select_q)) begin
                        pend_q      <= cand_q;
                        state_q     <= PENDING;
                        switching_q <= 1'b1;
                    end else begin
                        switching_q <= 1'b0;
                    end
                end
                PENDING: begin
                    if (commit) begin
                        select_q <= pend_q;
                        if (BLANK_FRAMES == 0) begin
                            state_q     <= IDLE;
                            switching_q <= 1'b0;
                        end else begin
                            bcnt_q      <= BLANK_INIT;
                            blank_q     <= 1'b1;
                            state_q     <= BLANK;
                            switching_q <= 1'b1;
                        end
                    end else if (swReq && (cand_q == select_q)) begin
                        state_q     <= IDLE;
                        switching_q <= 1'b0;
                    end else if (swReq && (cand_q != pend_q)) begin
                        pend_q <= cand_q;
                    end
                end
                BLANK: begin
                    if (commit) begin
                        if (bcnt_q == 4'd1) begin
                            blank_q     <= 1'b0;
                            state_q     <= IDLE;
                            switching_q <= 1'b0;
                        end else begin
                            bcnt_q <= bcnt_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    blank_q     <= 1'b0;
                    switching_q <= 1'b0;
                end
            endcase
        end
    end

    assign oSelect     = select_q;
    assign oBlank      = blank_q;
    assign oSwitching  = switching_q;
    assign oErr        = err_q;
    assign oFrameCount = frameCnt_q;

endmodule

// File: tb/tb_display_mode_sequencer.sv
// Self-checking bench for display_mode_sequencer: directed scenarios plus randomized frames,
// all compared against a history-window reference model.
module tb_display_mode_sequencer;

    localparam int SEL_W   = 18;
    localparam int STABLE  = 4;
    localparam int VBLANK  = 5;
    localparam int BFRAMES = 1;

    logic             iClk   = 1'b0;
    logic             iRst_n = 1'b0;
    logic             iFval  = 1'b0;
    logic [SEL_W-1:0] iSwitch = '0;
    logic [SEL_W-1:0] oSelect;
    logic             oBlank;
    logic             oSwitching;
    logic             oErr;
    logic [15:0]      oFrameCount;

    int vectorCount = 0;
    int missCount   = 0;

    display_mode_sequencer #(
        .SEL_W        (SEL_W),
        .STABLE_CYCLES(STABLE),
        .VBLANK_CYCLES(VBLANK),
        .BLANK_FRAMES (BFRAMES),
        .DEFAULT_MODE (18'd2)
    ) dut (
        .iClk       (iClk),
        .iRst_n     (iRst_n),
        .iFval      (iFval),
        .iSwitch    (iSwitch),
        .oSelect    (oSelect),
        .oBlank     (oBlank),
        .oSwitching (oSwitching),
        .oErr       (oErr),
        .oFrameCount(oFrameCount)
    );

    always #5 iClk = ~iClk;

    // Reference model: switch acceptance is judged from a window of raw samples, not a counter.
    int hist[$];
    int refSel;
    int refPend;
    bit refPendValid;
    int refBlankLeft;
    bit refErr;
    int refLowRun;
    bit refPrevFval;
    int refFrames;
    bit checkEn = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit histStable();
        int last;
        last = hist.size() - 3;
        if (last < STABLE) return 1'b0;
        for (int k = 1; k <= STABLE; k++) begin
            if (hist[last-k] != hist[last]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void modelReset();
        hist.delete();
        hist.push_back(-1);
        hist.push_back(0);
        hist.push_back(0);
        hist.push_back(0);
        refSel       = 2;
        refPend      = 0;
        refPendValid = 1'b0;
        refBlankLeft = 0;
        refErr       = 1'b0;
        refLowRun    = 0;
        refPrevFval  = 1'b0;
        refFrames    = 0;
    endfunction

    function automatic void modelStep(input bit fval, input int sw);
        int cand;
        bit stable;
        bit ok;
        bit commit;
        cand   = hist[hist.size()-3];
        stable = histStable();
        ok     = stable && ($countones(cand) == 1);
        commit = !fval && (refLowRun == VBLANK - 1);
        refErr = stable && !ok;
        if (refBlankLeft > 0) begin
            if (commit) refBlankLeft--;
        end else if (refPendValid) begin
            if (commit) begin
                refSel       = refPend;
                refPendValid = 1'b0;
                refBlankLeft = BFRAMES;
            end else if (ok && cand == refSel) begin
                refPendValid = 1'b0;
            end else if (ok && cand != refPend) begin
                refPend = cand;
            end
        end else if (ok && cand != refSel) begin
            refPend      = cand;
            refPendValid = 1'b1;
        end
        refLowRun = fval ? 0 : refLowRun + 1;
        if (fval && !refPrevFval) refFrames = (refFrames + 1) % 65536;
        refPrevFval = fval;
        hist.push_back(sw);
        if (hist.size() > STABLE + 4) void'(hist.pop_front());
    endfunction

    always @(posedge iClk) begin
        if (!iRst_n) begin
            modelReset();
            checkEn = 1'b1;
        end else if (checkEn) begin
            modelStep(iFval, int'(iSwitch));
        end
    end

    always @(negedge iClk) begin
        if (checkEn) begin
            checkOutput("oSelect", 32'(oSelect), 32'(refSel));
            checkOutput("oBlank", 32'(oBlank), 32'(refBlankLeft > 0));
            checkOutput("oErr", 32'(oErr), 32'(refErr));
            checkOutput("oSwitching", 32'(oSwitching), 32'(refPendValid || refBlankLeft > 0));
            checkOutput("oFrameCount", 32'(oFrameCount), 32'(refFrames));
        end
    end

    task automatic tick(input logic fval, input logic [SEL_W-1:0] sw);
        @(negedge iClk);
        iFval   = fval;
        iSwitch = sw;
    endtask

    task automatic applyStimulus(input int activeLen, input int blankLen, input logic [SEL_W-1:0] sw);
        for (int i = 0; i < activeLen; i++) tick(1'b1, sw);
        for (int i = 0; i < blankLen; i++) tick(1'b0, sw);
    endtask

    task automatic doReset(input int cycles);
        @(negedge iClk);
        iRst_n = 1'b0;
        repeat (cycles) @(negedge iClk);
        iRst_n = 1'b1;
    endtask

    function automatic logic [SEL_W-1:0] randomSwitch();
        logic [SEL_W-1:0] v;
        case ($urandom_range(0, 3))
            0:       v = SEL_W'(1) << $urandom_range(0, SEL_W - 1);
            1:       v = SEL_W'(1) << $urandom_range(1, 4);
            2:       v = '0;
            default: v = SEL_W'($urandom());
        endcase
        return v;
    endfunction

    initial begin
        logic [SEL_W-1:0] sw;

        doReset(2);

        // Idle frames with no switch pressed.
        repeat (3) applyStimulus(20, 10, 18'd0);
        checkOutput("s1_select", 32'(oSelect), 32'd2);
        checkOutput("s1_frames", 32'(oFrameCount), 32'd3);

        // Clean request: commit in the first blank, one blanking frame after.
        applyStimulus(20, 10, 18'd4);
        checkOutput("s2_select_committed", 32'(oSelect), 32'd4);
        checkOutput("s2_blank_high", 32'(oBlank), 32'd1);
        repeat (2) applyStimulus(20, 10, 18'd4);
        checkOutput("s2_blank_cleared", 32'(oBlank), 32'd0);
        checkOutput("s2_switching_low", 32'(oSwitching), 32'd0);

        // Bouncing switch settles on 8.
        for (int i = 0; i < 20; i++) tick(1'b1, (((i / 2) % 2) != 0 || i >= 12) ? 18'd8 : 18'd4);
        for (int i = 0; i < 10; i++) tick(1'b0, 18'd8);
        applyStimulus(20, 10, 18'd8);
        checkOutput("s3_select", 32'(oSelect), 32'd8);
        checkOutput("s3_blank", 32'(oBlank), 32'd0);

        // Multi-bit request flags an error; then a pending request is cancelled.
        iSwitch = 18'd12;
        doReset(1);
        applyStimulus(20, 10, 18'd12);
        checkOutput("s4_err", 32'(oErr), 32'd1);
        checkOutput("s4_select_held", 32'(oSelect), 32'd2);
        for (int i = 0; i < 30; i++) tick(1'b1, (i < 12) ? 18'd16 : 18'd2);
        for (int i = 0; i < 10; i++) tick(1'b0, 18'd2);
        checkOutput("s4_cancel_select", 32'(oSelect), 32'd2);
        checkOutput("s4_cancel_switching", 32'(oSwitching), 32'd0);
        checkOutput("s4_cancel_blank", 32'(oBlank), 32'd0);

        // Short blank must not commit.
        applyStimulus(20, 3, 18'd32);
        checkOutput("s5_short_blank_select", 32'(oSelect), 32'd2);
        checkOutput("s5_still_pending", 32'(oSwitching), 32'd1);
        applyStimulus(20, 10, 18'd32);
        checkOutput("s5_long_blank_select", 32'(oSelect), 32'd32);
        checkOutput("s5_long_blank_blank", 32'(oBlank), 32'd1);
        applyStimulus(20, 10, 18'd32);

        // Reset during a blanking sequence.
        applyStimulus(20, 10, 18'd64);
        checkOutput("s6_select_before", 32'(oSelect), 32'd64);
        checkOutput("s6_blank_before", 32'(oBlank), 32'd1);
        for (int i = 0; i < 5; i++) tick(1'b1, 18'd64);
        doReset(1);
        checkOutput("s6_reset_select", 32'(oSelect), 32'd2);
        checkOutput("s6_reset_blank", 32'(oBlank), 32'd0);
        checkOutput("s6_reset_switching", 32'(oSwitching), 32'd0);
        checkOutput("s6_reset_frames", 32'(oFrameCount), 32'd0);

        // Randomized frames with random switch activity and occasional resets.
        sw = 18'd4;
        for (int f = 0; f < 40; f++) begin
            int activeLen;
            int blankLen;
            activeLen = int'($urandom_range(4, 25));
            blankLen  = int'($urandom_range(1, 12));
            if ($urandom_range(0, 19) == 0) doReset(int'($urandom_range(1, 2)));
            for (int i = 0; i < activeLen + blankLen; i++) begin
                if ($urandom_range(0, 5) == 0) sw = randomSwitch();
                tick((i < activeLen) ? 1'b1 : 1'b0, sw);
            end
        end

        repeat (3) tick(1'b0, sw);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
